// File: rtl/player_input_arbiter_pkg.sv
// Shared game constants: PS/2 scan codes for both players and pause,
// move encoding, mover state encoding and the key-to-index lookup.
package player_input_arbiter_pkg;

  localparam int BREAK_BIT = 9;

  localparam logic [7:0] KEY_P0_UP    = 8'h1D;
  localparam logic [7:0] KEY_P0_DOWN  = 8'h1B;
  localparam logic [7:0] KEY_P0_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_P0_RIGHT = 8'h23;
  localparam logic [7:0] KEY_P1_UP    = 8'h43;
  localparam logic [7:0] KEY_P1_DOWN  = 8'h42;
  localparam logic [7:0] KEY_P1_LEFT  = 8'h3B;
  localparam logic [7:0] KEY_P1_RIGHT = 8'h4B;
  localparam logic [7:0] KEY_PAUSE    = 8'h4D;

  localparam logic [3:0] KEY_IDX_PAUSE = 4'd8;
  localparam logic [3:0] KEY_IDX_NONE  = 4'hF;

  typedef enum logic [1:0] {
    MOVE_NONE  = 2'b00,
    MOVE_RIGHT = 2'b01,
    MOVE_LEFT  = 2'b10
  } move_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WALK_LEFT  = 3'd1,
    WALK_RIGHT = 3'd2,
    JUMP       = 3'd3,
    L_JUMP     = 3'd4,
    R_JUMP     = 3'd5
  } mover_state_e;

  // Held-bit layout: player p owns bits 4p+{0 up, 1 down, 2 left, 3 right}.
  function automatic logic [3:0] key_index(input logic [7:0] code);
    case (code)
      KEY_P0_UP:    return 4'd0;
      KEY_P0_DOWN:  return 4'd1;
      KEY_P0_LEFT:  return 4'd2;
      KEY_P0_RIGHT: return 4'd3;
      KEY_P1_UP:    return 4'd4;
      KEY_P1_DOWN:  return 4'd5;
      KEY_P1_LEFT:  return 4'd6;
      KEY_P1_RIGHT: return 4'd7;
      KEY_PAUSE:    return KEY_IDX_PAUSE;
      default:      return KEY_IDX_NONE;
    endcase
  endfunction

endpackage

// File: rtl/player_input_arbiter_frame_tick_gen.sv
// Free-running frame counter; o_wrap flags the last count, o_tick is the
// registered, enable-gated pulse that follows it.
module frame_tick_gen #(
  parameter int TICK_DIV = 1000000,
  parameter int CNT_W    = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_wrap,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  assign o_wrap = (r_cnt == LAST);
  assign o_tick = r_tick;

  // The count never stops; only the outgoing pulse is gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= o_wrap & i_enable;
      r_cnt  <= o_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/player_input_arbiter.sv
// Splits the decoded PS/2 key stream into held-key, direction, jump and
// pause state for two players, with one shared frame tick.
module player_input_arbiter
  import player_input_arbiter_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int CNT_W    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_key_valid,
  input  logic [9:0] i_key_code,
  output logic       o_frame_tick,
  output logic       o_paused,
  output logic [1:0] o_p0_move,
  output logic       o_p0_down,
  output logic       o_p0_jump,
  output logic [1:0] o_p1_move,
  output logic       o_p1_down,
  output logic       o_p1_jump,
  output logic       o_unmapped
);

  logic [3:0] w_idx;
  logic       w_brk;
  logic       w_mapped;
  logic       w_unused_bit8;

  assign w_idx         = key_index(i_key_code[7:0]);
  assign w_brk         = i_key_code[BREAK_BIT];
  assign w_mapped      = (w_idx != KEY_IDX_NONE);
  assign w_unused_bit8 = i_key_code[8];

  logic [7:0] r_held;
  logic [7:0] w_held_nxt;
  logic [7:0] w_rise;
  logic       r_pause_held;
  logic       w_pause_held_nxt;
  logic       r_paused;
  logic       w_paused_nxt;
  logic       r_unmapped;

  // Pause toggles only on the 0->1 edge of its own held bit.
  always_comb begin
    w_held_nxt       = r_held;
    w_rise           = '0;
    w_pause_held_nxt = r_pause_held;
    w_paused_nxt     = r_paused;
    if (i_key_valid && w_mapped) begin
      if (w_idx == KEY_IDX_PAUSE) begin
        w_pause_held_nxt = ~w_brk;
        if (!w_brk && !r_pause_held) w_paused_nxt = ~r_paused;
      end else begin
        w_held_nxt[w_idx[2:0]] = ~w_brk;
        w_rise[w_idx[2:0]]     = ~w_brk & ~r_held[w_idx[2:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held       <= '0;
      r_pause_held <= 1'b0;
      r_paused     <= 1'b0;
      r_unmapped   <= 1'b0;
    end else begin
      r_held       <= w_held_nxt;
      r_pause_held <= w_pause_held_nxt;
      r_paused     <= w_paused_nxt;
      r_unmapped   <= i_key_valid & ~w_mapped;
    end
  end

  logic w_wrap;
  logic w_tick_en;
  logic w_tick_nxt;

  assign w_tick_en  = ~w_paused_nxt;
  assign w_tick_nxt = w_wrap & w_tick_en;

  frame_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_frame_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (w_tick_en),
    .o_wrap   (w_wrap),
    .o_tick   (o_frame_tick)
  );

  logic [1:0] w_move [2];
  logic       w_down [2];
  logic       w_jump [2];

  for (genvar p = 0; p < 2; p++) begin : g_player
    localparam int UP = 4 * p;
    localparam int DN = 4 * p + 1;
    localparam int LF = 4 * p + 2;
    localparam int RT = 4 * p + 3;

    move_e r_last_dir;
    move_e w_last_dir_nxt;
    move_e w_move_nxt;
    move_e r_move;
    logic  r_jump_pend;
    logic  w_jump_pend_nxt;
    logic  r_down;
    logic  r_jump;

    // Newest pressed direction wins while both are held; a new jump press
    // beats the clear from a tick in the same cycle.
    always_comb begin
      w_last_dir_nxt = r_last_dir;
      if (w_rise[LF])      w_last_dir_nxt = MOVE_LEFT;
      else if (w_rise[RT]) w_last_dir_nxt = MOVE_RIGHT;

      w_move_nxt = MOVE_NONE;
      if (w_held_nxt[LF] && w_held_nxt[RT]) w_move_nxt = w_last_dir_nxt;
      else if (w_held_nxt[LF])              w_move_nxt = MOVE_LEFT;
      else if (w_held_nxt[RT])              w_move_nxt = MOVE_RIGHT;

      w_jump_pend_nxt = w_rise[UP] | (r_jump_pend & ~o_frame_tick);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_last_dir  <= MOVE_NONE;
        r_jump_pend <= 1'b0;
        r_move      <= MOVE_NONE;
        r_down      <= 1'b0;
        r_jump      <= 1'b0;
      end else begin
        r_last_dir  <= w_last_dir_nxt;
        r_jump_pend <= w_jump_pend_nxt;
        r_move      <= w_paused_nxt ? MOVE_NONE : w_move_nxt;
        r_down      <= w_held_nxt[DN] & ~w_paused_nxt;
        r_jump      <= w_tick_nxt & w_jump_pend_nxt;
      end
    end

    assign w_move[p] = r_move;
    assign w_down[p] = r_down;
    assign w_jump[p] = r_jump;
  end

  assign o_paused   = r_paused;
  assign o_unmapped = r_unmapped;
  assign o_p0_move  = w_move[0];
  assign o_p0_down  = w_down[0];
  assign o_p0_jump  = w_jump[0];
  assign o_p1_move  = w_move[1];
  assign o_p1_down  = w_down[1];
  assign o_p1_jump  = w_jump[1];

endmodule
